code_checker: RTL and testbench
===============================

Name: code_checker

Overview:
- Reader-side companion to the player load register: consumes the stored 4-bit code and validates player guesses entered on switches plus an enter button.
- Sits between the load register output and the game display/LED logic.
- Grants on a match; counts misses; locks the player out for a fixed time after MAX_TRIES misses.

Parameters:
- WIDTH, 4, code and guess width in bits.
- MAX_TRIES, 3, misses allowed before lockout; legal range 1 to 2^TRY_W-1.
- TRY_W, 2, width of tries_left.
- LOCK_CYCLES, 200, lockout duration in clk cycles; legal range 1 to 2^LOCK_W-1.
- LOCK_W, 8, width of the lockout counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- stored_code  input  WIDTH  code from the load register.
- code_valid  input  1  high while stored_code holds a loaded value.
- guess  input  WIDTH  player guess (switches), synchronous to clk.
- enter  input  1  player enter button, level, synchronous to clk.
- granted  output  1  level, high while in GRANTED.
- denied  output  1  one-cycle pulse per miss that does not lock.
- locked  output  1  level, high while in LOCKED.
- tries_left  output  TRY_W  remaining misses.

Behaviour:
- Reset values: granted=0, denied=0, locked=0, tries_left=MAX_TRIES, state=WAIT_CODE, guess_q=0, lock counter=0.
- Enter edge detector: enter_prev register resets to 1. An edge is enter=1 and enter_prev=0 at a clk rise.
  - A button held through reset release is ignored.
  - A button held high produces exactly one edge.
- All outputs are registered.
- States: WAIT_CODE, READY, CHECK, GRANTED, LOCKED.
- WAIT_CODE:
  - Enter edges are ignored.
  - code_valid=1 -> READY.
- READY:
  - An enter edge latches guess into guess_q and moves to CHECK.
- CHECK (exactly 1 cycle), compares guess_q with stored_code:
  - Equal -> GRANTED; tries_left restores to MAX_TRIES.
  - Unequal and tries_left>1 -> decrement tries_left, pulse denied, go to READY.
  - Unequal and tries_left==1 -> tries_left=0, load lock counter with LOCK_CYCLES, go to LOCKED; denied is not pulsed.
- Latency: edge sampled at rise N, CHECK at N+1, granted/denied/locked visible after rise N+2.
- GRANTED:
  - granted=1.
  - An enter edge -> READY, granted=0.
- LOCKED:
  - locked=1; enter edges are ignored.
  - The counter decrements every cycle. When it is 1 at a rise: go to READY, locked=0, tries_left=MAX_TRIES.
- code_valid=0 at a rise in READY, CHECK or GRANTED -> WAIT_CODE, tries_left=MAX_TRIES, granted=0, no denied pulse.
- In LOCKED, code_valid is ignored, so reloading a code cannot bypass the lockout. Lockout completes, then READY, then WAIT_CODE on the next rise if code_valid is still 0.
- Comparison is full WIDTH, unsigned equality.
- Asynchronous rst at any point immediately forces the reset values, including mid-CHECK or mid-LOCKED.

Optional Feature:
- Macro: CODE_CHECKER_HINT_EN.
- Defined:
  - Adds output ports hint_high and hint_low (1 bit each), reset 0.
  - Both pulse together with denied for one cycle: hint_high=1 if guess_q > stored_code (unsigned); hint_low=1 if guess_q < stored_code.
  - No hint on the locking miss.
- Not defined: the ports and their logic are absent; all other behaviour is identical.

Test Plan (LOCK_CYCLES=10 in bench):
1. Reset; stored_code=4'b1001, code_valid=1; guess=4'b1001, enter pulse -> granted=1 two rises after the sampled edge; tries_left=3; denied never asserted.
2. guess=4'b0101, three enter pulses -> denied pulses with tries_left 2 then 1; third miss gives locked=1, tries_left=0, no denied pulse; locked drops exactly 10 cycles later; tries_left=3.
3. enter held high 6 cycles in READY -> one evaluation only; tries_left 3->2, one denied pulse.
4. One miss (tries_left=2), then code_valid=0 -> WAIT_CODE, tries_left=3. Repeat into LOCKED and drop code_valid -> locked stays 1 for the full 10 cycles.
5. rst asserted mid-CHECK -> all outputs reset asynchronously. enter held high across rst release -> no evaluation until enter falls and rises again.
6. With CODE_CHECKER_HINT_EN: guess=4'b1100 vs 4'b1001 -> hint_high=1, hint_low=0, coincident with denied. guess=4'b0011 -> hint_low=1.

Source files
------------

// File: rtl/code_checker.sv
// Guess checker for the stored player code: grants on a match, counts misses, locks out after MAX_TRIES.
// Optional CODE_CHECKER_HINT_EN adds hint_high/hint_low pulses alongside denied.
module code_checker #(
  parameter int WIDTH       = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TRY_W       = 2,
  parameter int LOCK_CYCLES = 200,
  parameter int LOCK_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] stored_code,
  input  logic             code_valid,
  input  logic [WIDTH-1:0] guess,
  input  logic             enter,
  output logic             granted,
  output logic             denied,
  output logic             locked,
`ifdef CODE_CHECKER_HINT_EN
  output logic             hint_high,
  output logic             hint_low,
`endif
  output logic [TRY_W-1:0] tries_left
);

  // state     | meaning
  // WAIT_CODE | no valid code loaded, guesses ignored
  // READY     | waiting for an enter edge
  // CHECK     | one-cycle compare of guess_q against stored_code
  // GRANTED   | match found, held until next enter edge
  // LOCKED    | lockout timer running, all input ignored
  typedef enum logic [2:0] {WAIT_CODE, READY, CHECK, GRANTED, LOCKED} state_t;

  localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES);

  state_t             state, state_nx;
  logic [TRY_W-1:0]   tries, tries_nx;
  logic [LOCK_W-1:0]  lock_cnt, lock_cnt_nx;
  logic [WIDTH-1:0]   guess_q, guess_q_nx;
  logic               miss, miss_nx;
  logic               enter_prev;
  logic               enter_edge;

  assign enter_edge = enter & ~enter_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_CODE;
      tries      <= TRY_MAX;
      lock_cnt   <= '0;
      guess_q    <= '0;
      miss       <= 1'b0;
      enter_prev <= 1'b1;
    end else begin
      state      <= state_nx;
      tries      <= tries_nx;
      lock_cnt   <= lock_cnt_nx;
      guess_q    <= guess_q_nx;
      miss       <= miss_nx;
      enter_prev <= enter;
    end
  end

  always_comb begin
    state_nx    = state;
    tries_nx    = tries;
    lock_cnt_nx = lock_cnt;
    guess_q_nx  = guess_q;
    miss_nx     = 1'b0;
    case (state)
      WAIT_CODE: if (code_valid) state_nx = READY;
      READY: begin
        if (!code_valid) begin
          state_nx = WAIT_CODE;
          tries_nx = TRY_MAX;
        end else if (enter_edge) begin
          guess_q_nx = guess;
          state_nx   = CHECK;
        end
      end
      CHECK: begin
        if (!code_valid) begin
          state_nx = WAIT_CODE;
          tries_nx = TRY_MAX;
        end else if (guess_q == stored_code) begin
          state_nx = GRANTED;
          tries_nx = TRY_MAX;
        end else if (tries > TRY_W'(1)) begin
          state_nx = READY;
          tries_nx = tries - TRY_W'(1);
          miss_nx  = 1'b1;
        end else begin
          // Final miss locks silently: no denied pulse, no hint.
          state_nx    = LOCKED;
          tries_nx    = '0;
          lock_cnt_nx = LOCK_LOAD;
        end
      end
      GRANTED: begin
        if (!code_valid) begin
          state_nx = WAIT_CODE;
          tries_nx = TRY_MAX;
        end else if (enter_edge) begin
          state_nx = READY;
        end
      end
      LOCKED: begin
        if (lock_cnt <= LOCK_W'(1)) begin
          state_nx    = READY;
          tries_nx    = TRY_MAX;
          lock_cnt_nx = '0;
        end else begin
          lock_cnt_nx = lock_cnt - LOCK_W'(1);
        end
      end
      default: state_nx = WAIT_CODE;
    endcase
  end

  // Outputs trail the state by one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      granted    <= 1'b0;
      denied     <= 1'b0;
      locked     <= 1'b0;
      tries_left <= TRY_MAX;
    end else begin
      granted    <= (state == GRANTED);
      denied     <= miss;
      locked     <= (state == LOCKED);
      tries_left <= tries;
    end
  end

`ifdef CODE_CHECKER_HINT_EN
  logic hint_high_q, hint_low_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hint_high_q <= 1'b0;
      hint_low_q  <= 1'b0;
      hint_high   <= 1'b0;
      hint_low    <= 1'b0;
    end else begin
      hint_high_q <= miss_nx & (guess_q > stored_code);
      hint_low_q  <= miss_nx & (guess_q < stored_code);
      hint_high   <= hint_high_q;
      hint_low    <= hint_low_q;
    end
  end
`endif

endmodule

// File: tb/tb_code_checker.sv
// Scoreboard bench for code_checker: per-cycle stimulus queued with expected outputs, compared each cycle.
module tb_code_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] stored_code = 4'b1001;
  logic [3:0] guess = 4'b0000;
  logic       code_valid = 1'b0;
  logic       enter = 1'b0;
  logic       granted, denied, locked;
  logic [1:0] tries_left;
  wire        hint_high, hint_low;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       cv;
    logic [3:0] g;
  } stim_t;

  stim_t      sq[$];
  logic [6:0] eq[$];
  stim_t      s;
  logic [6:0] e;
  int         step;

`ifdef CODE_CHECKER_HINT_EN
  localparam logic [6:0] MASK = 7'h7f;
  code_checker #(.WIDTH(4), .MAX_TRIES(3), .TRY_W(2), .LOCK_CYCLES(10), .LOCK_W(8)) dut (
    .clk(clk), .rst(rst), .stored_code(stored_code), .code_valid(code_valid),
    .guess(guess), .enter(enter), .granted(granted), .denied(denied),
    .locked(locked), .hint_high(hint_high), .hint_low(hint_low), .tries_left(tries_left));
`else
  localparam logic [6:0] MASK = 7'h7c;
  assign hint_high = 1'b0;
  assign hint_low  = 1'b0;
  code_checker #(.WIDTH(4), .MAX_TRIES(3), .TRY_W(2), .LOCK_CYCLES(10), .LOCK_W(8)) dut (
    .clk(clk), .rst(rst), .stored_code(stored_code), .code_valid(code_valid),
    .guess(guess), .enter(enter), .granted(granted), .denied(denied),
    .locked(locked), .tries_left(tries_left));
`endif

  always #5 clk = ~clk;

  // {granted, denied, locked, tries_left, hint_high, hint_low}
  wire [6:0] obs = {granted, denied, locked, tries_left, hint_high, hint_low};

  function automatic void push(logic en, logic cv, logic [3:0] g, logic gr, logic dn,
                               logic lk, logic [1:0] t, logic hh, logic hl);
    stim_t st;
    st.en = en; st.cv = cv; st.g = g;
    sq.push_back(st);
    eq.push_back({gr, dn, lk, t, hh, hl});
  endfunction

  // Non-locking miss: edge, compare, denied pulse, idle.
  function automatic void push_miss(logic [3:0] g, logic [1:0] t, logic hh, logic hl);
    push(1, 1, g, 0, 0, 0, t, 0, 0);
    push(0, 1, g, 0, 0, 0, t, 0, 0);
    push(0, 1, g, 0, 1, 0, t - 2'd1, hh, hl);
    push(0, 1, g, 0, 0, 0, t - 2'd1, 0, 0);
  endfunction

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ((obs & MASK) !== (7'b0001100 & MASK)) begin
      errors++; $display("FAIL reset_held obs=%b exp=%b", obs & MASK, 7'b0001100 & MASK);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ((obs & MASK) !== (7'b0001100 & MASK)) begin
      errors++; $display("FAIL reset_release obs=%b exp=%b", obs & MASK, 7'b0001100 & MASK);
    end
  endtask

  task automatic test_grant();
    push(0, 1, 4'b1001, 0, 0, 0, 3, 0, 0);
    push(1, 1, 4'b1001, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b1001, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b1001, 1, 0, 0, 3, 0, 0);
    push(0, 1, 4'b1001, 1, 0, 0, 3, 0, 0);
    push(1, 1, 4'b1001, 1, 0, 0, 3, 0, 0);
    push(0, 1, 4'b1001, 0, 0, 0, 3, 0, 0);
    step = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); enter = s.en; code_valid = s.cv; guess = s.g;
      @(posedge clk); @(negedge clk);
      e = eq.pop_front(); checks++;
      if ((obs & MASK) !== (e & MASK)) begin
        errors++; $display("FAIL grant step %0d obs=%b exp=%b", step, obs & MASK, e & MASK);
      end
      step++;
    end
  endtask

  task automatic test_lockout();
    push_miss(4'b0101, 3, 0, 1);
    push_miss(4'b0101, 2, 0, 1);
    push(1, 1, 4'b0101, 0, 0, 0, 1, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) push(i == 3, 1, 4'b0101, 0, 0, 1, 0, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    step = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); enter = s.en; code_valid = s.cv; guess = s.g;
      @(posedge clk); @(negedge clk);
      e = eq.pop_front(); checks++;
      if ((obs & MASK) !== (e & MASK)) begin
        errors++; $display("FAIL lockout step %0d obs=%b exp=%b", step, obs & MASK, e & MASK);
      end
      step++;
    end
  endtask

  task automatic test_hold();
    push(1, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(1, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(1, 1, 4'b0101, 0, 1, 0, 2, 0, 1);
    push(1, 1, 4'b0101, 0, 0, 0, 2, 0, 0);
    push(1, 1, 4'b0101, 0, 0, 0, 2, 0, 0);
    push(1, 1, 4'b0101, 0, 0, 0, 2, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 2, 0, 0);
    step = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); enter = s.en; code_valid = s.cv; guess = s.g;
      @(posedge clk); @(negedge clk);
      e = eq.pop_front(); checks++;
      if ((obs & MASK) !== (e & MASK)) begin
        errors++; $display("FAIL hold step %0d obs=%b exp=%b", step, obs & MASK, e & MASK);
      end
      step++;
    end
  endtask

  task automatic test_code_valid_drop();
    push(0, 0, 4'b0101, 0, 0, 0, 2, 0, 0);
    push(0, 0, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(1, 0, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 0, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push_miss(4'b0101, 3, 0, 1);
    push_miss(4'b0101, 2, 0, 1);
    push(1, 1, 4'b0101, 0, 0, 0, 1, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) push(0, 0, 4'b0101, 0, 0, 1, 0, 0, 0);
    push(0, 0, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(1, 0, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 0, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 0, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    step = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); enter = s.en; code_valid = s.cv; guess = s.g;
      @(posedge clk); @(negedge clk);
      e = eq.pop_front(); checks++;
      if ((obs & MASK) !== (e & MASK)) begin
        errors++; $display("FAIL cv_drop step %0d obs=%b exp=%b", step, obs & MASK, e & MASK);
      end
      step++;
    end
  endtask

  task automatic test_async_reset();
    push_miss(4'b0101, 3, 0, 1);
    push(1, 1, 4'b0101, 0, 0, 0, 2, 0, 0);
    step = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); enter = s.en; code_valid = s.cv; guess = s.g;
      @(posedge clk); @(negedge clk);
      e = eq.pop_front(); checks++;
      if ((obs & MASK) !== (e & MASK)) begin
        errors++; $display("FAIL pre_rst step %0d obs=%b exp=%b", step, obs & MASK, e & MASK);
      end
      step++;
    end
    // DUT is now in CHECK; reset lands between clock edges.
    #2 rst = 1'b1; enter = 1'b1;
    #1 checks++;
    if ((obs & MASK) !== (7'b0001100 & MASK)) begin
      errors++; $display("FAIL async_rst obs=%b exp=%b", obs & MASK, 7'b0001100 & MASK);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(1, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(1, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b0101, 0, 0, 0, 3, 0, 0);
    push(0, 1, 4'b0101, 0, 1, 0, 2, 0, 1);
    push(0, 1, 4'b0101, 0, 0, 0, 2, 0, 0);
    step = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); enter = s.en; code_valid = s.cv; guess = s.g;
      @(posedge clk); @(negedge clk);
      e = eq.pop_front(); checks++;
      if ((obs & MASK) !== (e & MASK)) begin
        errors++; $display("FAIL post_rst step %0d obs=%b exp=%b", step, obs & MASK, e & MASK);
      end
      step++;
    end
  endtask

  task automatic test_hints();
    push(1, 1, 4'b1001, 0, 0, 0, 2, 0, 0);
    push(0, 1, 4'b1001, 0, 0, 0, 2, 0, 0);
    push(0, 1, 4'b1001, 1, 0, 0, 3, 0, 0);
    push(1, 1, 4'b1001, 1, 0, 0, 3, 0, 0);
    push(0, 1, 4'b1001, 0, 0, 0, 3, 0, 0);
    push_miss(4'b1100, 3, 1, 0);
    push_miss(4'b0011, 2, 0, 1);
    step = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); enter = s.en; code_valid = s.cv; guess = s.g;
      @(posedge clk); @(negedge clk);
      e = eq.pop_front(); checks++;
      if ((obs & MASK) !== (e & MASK)) begin
        errors++; $display("FAIL hints step %0d obs=%b exp=%b", step, obs & MASK, e & MASK);
      end
      step++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_grant();
    test_lockout();
    test_hold();
    test_code_valid_drop();
    test_async_reset();
    test_hints();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
